// File: rtl/if_fetch_unit_pkg.sv
// Shared definitions for the fetch stage of the 5-stage pipeline.
package if_fetch_unit_pkg;

  localparam logic [31:0] NOP_INST = 32'h0000_0000;
  localparam int unsigned PC_STEP  = 4;

  typedef enum logic {
    FETCH,
    HOLD
  } fetch_state_t;

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: clear (bubble) wins over load; otherwise contents hold.
module if_id_reg
  import if_fetch_unit_pkg::*;
#(
  parameter int unsigned AddrW = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             load_i,
  input  logic             clear_i,
  input  logic [31:0]      inst_i,
  input  logic [AddrW-1:0] pc_i,
  output logic [31:0]      inst_o,
  output logic [AddrW-1:0] pc_o,
  output logic             valid_o
);

  logic [31:0]      inst_q, inst_d;
  logic [AddrW-1:0] pc_q, pc_d;
  logic             valid_q, valid_d;

  always_comb begin
    inst_d  = inst_q;
    pc_d    = pc_q;
    valid_d = valid_q;
    if (clear_i) begin
      inst_d  = NOP_INST;
      pc_d    = '0;
      valid_d = 1'b0;
    end else if (load_i) begin
      inst_d  = inst_i;
      pc_d    = pc_i;
      valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      inst_q  <= NOP_INST;
      pc_q    <= '0;
      valid_q <= 1'b0;
    end else begin
      inst_q  <= inst_d;
      pc_q    <= pc_d;
      valid_q <= valid_d;
    end
  end

  assign inst_o  = inst_q;
  assign pc_o    = pc_q;
  assign valid_o = valid_q;

endmodule

// File: rtl/if_fetch_unit.sv
// Instruction fetch stage: owns the PC, handshakes with instruction memory and feeds IF/ID.
module if_fetch_unit
  import if_fetch_unit_pkg::*;
#(
  parameter int unsigned        ADDR_W   = 32,
  parameter logic [ADDR_W-1:0]  RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              freeze,
  input  logic              branch_taken,
  input  logic [ADDR_W-1:0] branch_addr,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [31:0]       imem_rdata,
  input  logic              imem_ready,
  output logic [31:0]       inst_out,
  output logic [ADDR_W-1:0] pc_out,
  output logic              valid_out
);

  fetch_state_t      state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [31:0]       hold_inst_q, hold_inst_d;
  logic [ADDR_W-1:0] pc_next;
  logic              ifid_load, ifid_clear;
  logic [31:0]       ifid_inst;

  assign pc_next   = pc_q + ADDR_W'(PC_STEP);
  assign imem_addr = pc_q;
  assign imem_req  = (state_q == FETCH) && !rst;

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    hold_inst_d = hold_inst_q;
    ifid_load   = 1'b0;
    ifid_clear  = 1'b0;
    ifid_inst   = imem_rdata;
    if (branch_taken) begin
      // Redirect drops whatever memory returned this cycle and any held word.
      pc_d        = branch_addr;
      hold_inst_d = NOP_INST;
      state_d     = FETCH;
      ifid_clear  = 1'b1;
    end else begin
      unique case (state_q)
        FETCH: begin
          if (imem_ready && !freeze) begin
            ifid_load = 1'b1;
            pc_d      = pc_next;
          end else if (imem_ready && freeze) begin
            // Park the returned word so the fetch is not repeated after the stall.
            hold_inst_d = imem_rdata;
            state_d     = HOLD;
          end else if (!freeze) begin
            ifid_clear = 1'b1;
          end
        end
        HOLD: begin
          if (!freeze) begin
            ifid_load = 1'b1;
            ifid_inst = hold_inst_q;
            pc_d      = pc_next;
            state_d   = FETCH;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= FETCH;
      pc_q        <= RESET_PC;
      hold_inst_q <= NOP_INST;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      hold_inst_q <= hold_inst_d;
    end
  end

  if_id_reg #(
    .AddrW (ADDR_W)
  ) u_if_id_reg (
    .clk_i   (clk),
    .rst_i   (rst),
    .load_i  (ifid_load),
    .clear_i (ifid_clear),
    .inst_i  (ifid_inst),
    .pc_i    (pc_next),
    .inst_o  (inst_out),
    .pc_o    (pc_out),
    .valid_o (valid_out)
  );

endmodule

// File: tb/tb_if_fetch_unit.sv
// Directed bench for if_fetch_unit; memory returns address-tagged words (addr ^ 32'hC0DE_0000).
module tb_if_fetch_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        freeze = 1'b0;
  logic        branch_taken = 1'b0;
  logic [31:0] branch_addr = 32'h0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        imem_ready = 1'b1;
  logic [31:0] inst_out;
  logic [31:0] pc_out;
  logic        valid_out;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  assign imem_rdata = imem_addr ^ 32'hC0DE_0000;

  if_fetch_unit #(
    .ADDR_W   (32),
    .RESET_PC (32'h0000_0000)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .freeze       (freeze),
    .branch_taken (branch_taken),
    .branch_addr  (branch_addr),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .imem_rdata   (imem_rdata),
    .imem_ready   (imem_ready),
    .inst_out     (inst_out),
    .pc_out       (pc_out),
    .valid_out    (valid_out)
  );

  typedef struct {
    logic        rst;
    logic        freeze;
    logic        br;
    logic [31:0] baddr;
    logic        ready;
    logic        exp_req;
    logic [31:0] exp_addr;
    logic [31:0] exp_inst;
    logic [31:0] exp_pc;
    logic        exp_valid;
  } vec_t;

  localparam int NVEC = 18;
  vec_t vecs[NVEC];

  function automatic vec_t mk(logic r, logic f, logic b, logic [31:0] ba, logic rdy,
                              logic req, logic [31:0] addr, logic [31:0] inst,
                              logic [31:0] pc, logic vld);
    vec_t v;
    v.rst = r; v.freeze = f; v.br = b; v.baddr = ba; v.ready = rdy;
    v.exp_req = req; v.exp_addr = addr; v.exp_inst = inst; v.exp_pc = pc; v.exp_valid = vld;
    return v;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic drive(logic r, logic f, logic b, logic [31:0] ba, logic rdy);
    @(negedge clk);
    rst = r; freeze = f; branch_taken = b; branch_addr = ba; imem_ready = rdy;
    #1;
  endtask

  task automatic post(string tag, logic [31:0] inst, logic [31:0] pc, logic vld);
    @(posedge clk);
    #1;
    chk({tag, ".inst"}, inst_out, inst);
    chk({tag, ".pc"}, pc_out, pc);
    chk({tag, ".valid"}, {31'b0, valid_out}, {31'b0, vld});
  endtask

  initial begin
    //            rst f  br baddr          rdy  req addr           inst           pc             v
    vecs[0]  = mk(1, 0, 0, 32'h0,         1,   0, 32'h0,         32'h0,         32'h0,         0);
    vecs[1]  = mk(0, 0, 0, 32'h0,         1,   1, 32'h0,         32'hC0DE_0000, 32'h4,         1);
    vecs[2]  = mk(0, 0, 0, 32'h0,         1,   1, 32'h4,         32'hC0DE_0004, 32'h8,         1);
    vecs[3]  = mk(0, 0, 0, 32'h0,         0,   1, 32'h8,         32'h0,         32'h0,         0);
    vecs[4]  = mk(0, 0, 0, 32'h0,         0,   1, 32'h8,         32'h0,         32'h0,         0);
    vecs[5]  = mk(0, 0, 0, 32'h0,         1,   1, 32'h8,         32'hC0DE_0008, 32'hC,         1);
    vecs[6]  = mk(0, 1, 0, 32'h0,         1,   1, 32'hC,         32'hC0DE_0008, 32'hC,         1);
    vecs[7]  = mk(0, 1, 0, 32'h0,         1,   0, 32'hC,         32'hC0DE_0008, 32'hC,         1);
    vecs[8]  = mk(0, 1, 0, 32'h0,         1,   0, 32'hC,         32'hC0DE_0008, 32'hC,         1);
    vecs[9]  = mk(0, 0, 0, 32'h0,         1,   0, 32'hC,         32'hC0DE_000C, 32'h10,        1);
    vecs[10] = mk(0, 0, 0, 32'h0,         1,   1, 32'h10,        32'hC0DE_0010, 32'h14,        1);
    vecs[11] = mk(0, 1, 0, 32'h0,         1,   1, 32'h14,        32'hC0DE_0010, 32'h14,        1);
    vecs[12] = mk(0, 1, 1, 32'h100,       1,   0, 32'h14,        32'h0,         32'h0,         0);
    vecs[13] = mk(0, 0, 0, 32'h0,         1,   1, 32'h100,       32'hC0DE_0100, 32'h104,       1);
    vecs[14] = mk(0, 1, 0, 32'h0,         0,   1, 32'h104,       32'hC0DE_0100, 32'h104,       1);
    vecs[15] = mk(0, 0, 1, 32'hFFFF_FFFC, 1,   1, 32'h104,       32'h0,         32'h0,         0);
    vecs[16] = mk(0, 0, 0, 32'h0,         1,   1, 32'hFFFF_FFFC, 32'h3F21_FFFC, 32'h0,         1);
    vecs[17] = mk(0, 0, 0, 32'h0,         1,   1, 32'h0,         32'hC0DE_0000, 32'h4,         1);

    for (int i = 0; i < NVEC; i++) begin
      string tag;
      tag = $sformatf("vec%0d", i);
      drive(vecs[i].rst, vecs[i].freeze, vecs[i].br, vecs[i].baddr, vecs[i].ready);
      chk({tag, ".req"}, {31'b0, imem_req}, {31'b0, vecs[i].exp_req});
      chk({tag, ".addr"}, imem_addr, vecs[i].exp_addr);
      post(tag, vecs[i].exp_inst, vecs[i].exp_pc, vecs[i].exp_valid);
    end

    // Reset during HOLD with a simultaneous branch: reset wins, branch target ignored.
    drive(0, 1, 0, 32'h0, 1);
    chk("rsthold.pre_req", {31'b0, imem_req}, 32'h1);
    chk("rsthold.pre_addr", imem_addr, 32'h4);
    post("rsthold.enter", 32'hC0DE_0000, 32'h4, 1'b1);
    drive(1, 1, 1, 32'h200, 1);
    chk("rsthold.rst_req", {31'b0, imem_req}, 32'h0);
    post("rsthold.rst", 32'h0, 32'h0, 1'b0);
    drive(0, 0, 0, 32'h0, 1);
    chk("rsthold.after_req", {31'b0, imem_req}, 32'h1);
    chk("rsthold.after_addr", imem_addr, 32'h0);
    post("rsthold.after", 32'hC0DE_0000, 32'h4, 1'b1);

    // Wait stall that turns into a freeze, then a bubble: PC must not move throughout.
    drive(0, 0, 0, 32'h0, 0);
    post("stall.bubble", 32'h0, 32'h0, 1'b0);
    drive(0, 1, 0, 32'h0, 0);
    chk("stall.frz_addr", imem_addr, 32'h4);
    post("stall.frz", 32'h0, 32'h0, 1'b0);
    drive(0, 0, 0, 32'h0, 1);
    chk("stall.resume_addr", imem_addr, 32'h4);
    post("stall.resume", 32'hC0DE_0004, 32'h8, 1'b1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
